// File: rtl/timer_pkg.sv
// Shared types and default sizes for the countdown timer block.
package timer_pkg;

    localparam int DEFAULT_WIDTH    = 32;
    localparam int DEFAULT_PS_WIDTH = 8;

    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_RUN     = 2'd1,
        T_EXPIRED = 2'd2
    } timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale divider: while enabled, asserts tick once every ps_reg+1 cycles.
// A clear restarts the period so the first tick after it is a full period away.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PS_WIDTH = DEFAULT_PS_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PS_WIDTH-1:0] ps_reg,
    input  logic                enable,
    input  logic                clear,
    output logic                tick
);

    logic [PS_WIDTH-1:0] ps_cnt_q;
    logic [PS_WIDTH-1:0] ps_cnt_d;

    // The tick does not depend on clear; the owner decides which event wins.
    assign tick = enable && (ps_cnt_q == ps_reg);

    // Next phase of the divider: restart on clear or on the period boundary.
    always_comb begin
        // NOTE: default assignment first so every path drives ps_cnt_d and no latch is inferred.
        ps_cnt_d = ps_cnt_q;
        if (clear) begin
            ps_cnt_d = '0;
        end else if (enable) begin
            if (ps_cnt_q == ps_reg) begin
                ps_cnt_d = '0;
            end else begin
                ps_cnt_d = ps_cnt_q + PS_WIDTH'(1);
            end
        end
    end

    // Phase register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            ps_cnt_q <= '0;
        end else begin
            ps_cnt_q <= ps_cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Programmable down-counting timer with prescaler, one-shot or auto-reload
// operation, a one-cycle terminal-count pulse and a sticky interrupt flag.
// Per-edge event priority: reset > load > stop > start > tick.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PS_WIDTH = DEFAULT_PS_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_val,
    input  logic                start,
    input  logic                stop,
    input  logic                auto_reload,
    input  logic [PS_WIDTH-1:0] prescale,
    input  logic                irq_clr,
    output logic [WIDTH-1:0]    count,
    output logic                busy,
    output logic                tc,
    output logic                irq
);

    timer_state_t        state_q;
    timer_state_t        state_d;
    logic [WIDTH-1:0]    count_q;
    logic [WIDTH-1:0]    count_d;
    logic [WIDTH-1:0]    reload_q;
    logic [WIDTH-1:0]    reload_d;
    logic [PS_WIDTH-1:0] ps_reg_q;
    logic [PS_WIDTH-1:0] ps_reg_d;
    logic                tc_q;
    logic                tc_d;
    logic                irq_q;
    logic                irq_d;
    logic                busy_q;
    logic                irq_set;
    logic                ps_clear;
    logic                tick;

    timer_prescaler #(
        .PS_WIDTH (PS_WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .ps_reg (ps_reg_q),
        .enable (state_q == T_RUN),
        .clear  (ps_clear),
        .tick   (tick)
    );

    // FSM and count update, evaluated in priority order of the input events.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        ps_reg_d = ps_reg_q;
        tc_d     = 1'b0;
        irq_set  = 1'b0;
        ps_clear = 1'b0;

        if (load) begin
            // A load in RUN keeps counting from the new value.
            reload_d = load_val;
            count_d  = load_val;
            ps_clear = 1'b1;
            if (state_q == T_EXPIRED) begin
                state_d = T_IDLE;
            end
        end else if (stop) begin
            // A stop pulse also masks a simultaneous start.
            if (state_q == T_RUN) begin
                state_d  = T_IDLE;
                ps_clear = 1'b1;
            end
        end else if (start && (state_q != T_RUN)) begin
            // Resume from a nonzero count, else restart from the reload value.
            if (count_q != '0) begin
                state_d  = T_RUN;
                ps_reg_d = prescale;
                ps_clear = 1'b1;
            end else if (reload_q != '0) begin
                count_d  = reload_q;
                state_d  = T_RUN;
                ps_reg_d = prescale;
                ps_clear = 1'b1;
            end
        end else if (tick) begin
            // A zero count in RUN (after loading 0) simply holds.
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
                tc_d    = 1'b1;
                irq_set = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = T_EXPIRED;
                end
            end
        end
    end

    // Sticky interrupt: a new expiry beats a clear on the same edge.
    always_comb begin
        irq_d = irq_q;
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    // Registered state, datapath and flags with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= T_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            ps_reg_q <= '0;
            tc_q     <= 1'b0;
            irq_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            ps_reg_q <= ps_reg_d;
            tc_q     <= tc_d;
            irq_q    <= irq_d;
            busy_q   <= (state_d == T_RUN);
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign tc    = tc_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: a constant vector table, hand-written
// multi-cycle sequences, and a randomized run against a behavioural model.
module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [31:0] load_val;
    logic        start;
    logic        stop;
    logic        auto_reload;
    logic [7:0]  prescale;
    logic        irq_clr;
    logic [31:0] count;
    logic        busy;
    logic        tc;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    countdown_timer #(.WIDTH(32), .PS_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .prescale    (prescale),
        .irq_clr     (irq_clr),
        .count       (count),
        .busy        (busy),
        .tc          (tc),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 = stopped, 1 = counting, 2 = finished.
    // Ticks are derived from the number of counting cycles since the last
    // (re)start, load or stop: every (ps+1)-th such cycle is a tick.
    int          m_mode;
    logic [31:0] m_count;
    logic [31:0] m_reload;
    int unsigned m_ps;
    int unsigned m_elapsed;
    bit          m_tc;
    bit          m_irq;

    task automatic model_edge();
        bit fired;
        fired = 1'b0;
        m_tc  = 1'b0;
        if (!rst_n) begin
            m_mode = 0; m_count = 0; m_reload = 0; m_ps = 0; m_elapsed = 0; m_irq = 1'b0;
            return;
        end
        if (load) begin
            m_reload = load_val;
            m_count = load_val;
            m_elapsed = 0;
            if (m_mode == 2) m_mode = 0;
        end else if (stop) begin
            if (m_mode == 1) begin
                m_mode = 0;
                m_elapsed = 0;
            end
        end else if (start && m_mode != 1) begin
            if (m_count != 0 || m_reload != 0) begin
                if (m_count == 0) m_count = m_reload;
                m_mode = 1;
                m_ps = prescale;
                m_elapsed = 0;
            end
        end else if (m_mode == 1) begin
            m_elapsed++;
            if (m_elapsed % (m_ps + 1) == 0) begin
                if (m_count > 1) begin
                    m_count = m_count - 1;
                end else if (m_count == 1) begin
                    fired = 1'b1;
                    if (auto_reload) m_count = m_reload;
                    else begin
                        m_count = 0;
                        m_mode = 2;
                    end
                end
            end
        end
        m_tc = fired;
        if (fired) m_irq = 1'b1;
        else if (irq_clr) m_irq = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit ld, input int lv, input bit st,
                         input bit sp, input bit ar, input int ps, input bit ic);
        rst_n = r; load = ld; load_val = lv; start = st; stop = sp;
        auto_reload = ar; prescale = 8'(ps); irq_clr = ic;
    endtask

    typedef struct {
        bit          rst_n;
        bit          load;
        logic [31:0] load_val;
        bit          start;
        bit          stop;
        bit          irq_clr;
        logic [31:0] e_count;
        bit          e_busy;
        bit          e_tc;
        bit          e_irq;
    } vec_t;

    function automatic vec_t mk(bit r, bit ld, int lv, bit st, bit sp, bit ic,
                                int ec, bit eb, bit et, bit ei);
        vec_t v;
        v.rst_n = r; v.load = ld; v.load_val = lv; v.start = st; v.stop = sp;
        v.irq_clr = ic; v.e_count = ec; v.e_busy = eb; v.e_tc = et; v.e_irq = ei;
        return v;
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[20];
        int   ar_exp[12];

        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // One-shot, stop/start interplay, restart from expired (prescale 0, no reload).
        vecs[0]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 5, 0, 0, 0,  5, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 1, 0, 0,  5, 1, 0, 0);
        vecs[3]  = mk(1, 0, 0, 0, 0, 0,  4, 1, 0, 0);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0,  3, 1, 0, 0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 0,  2, 1, 0, 0);
        vecs[6]  = mk(1, 0, 0, 0, 0, 0,  1, 1, 0, 0);
        vecs[7]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 1);
        vecs[8]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        vecs[9]  = mk(1, 0, 0, 0, 0, 1,  0, 0, 0, 0);
        vecs[10] = mk(1, 0, 0, 1, 0, 0,  5, 1, 0, 0);
        vecs[11] = mk(1, 0, 0, 0, 1, 0,  5, 0, 0, 0);
        vecs[12] = mk(1, 1, 7, 0, 0, 0,  7, 0, 0, 0);
        vecs[13] = mk(1, 0, 0, 1, 1, 0,  7, 0, 0, 0);
        vecs[14] = mk(1, 0, 0, 1, 0, 0,  7, 1, 0, 0);
        vecs[15] = mk(1, 0, 0, 1, 1, 0,  7, 0, 0, 0);
        vecs[16] = mk(1, 0, 0, 1, 0, 0,  7, 1, 0, 0);
        vecs[17] = mk(1, 0, 0, 0, 0, 0,  6, 1, 0, 0);
        vecs[18] = mk(1, 0, 0, 1, 0, 0,  5, 1, 0, 0);
        vecs[19] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst_n, vecs[i].load, int'(vecs[i].load_val), vecs[i].start,
                  vecs[i].stop, 0, 0, vecs[i].irq_clr);
            cycle();
            check($sformatf("vec%0d_count", i), count, vecs[i].e_count);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].e_tc));
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].e_irq));
        end

        // Reset mid-run clears everything; a later start with nothing loaded is ignored.
        drive(1, 1, 10, 0, 0, 0, 0, 0); cycle();
        drive(1, 0, 0, 1, 0, 0, 0, 0);  cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle();
        check("midrun_count_before_rst", count, 7);
        drive(0, 0, 0, 0, 0, 0, 0, 0);  cycle();
        check("rst_count", count, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tc", 32'(tc), 0);
        check("rst_irq", 32'(irq), 0);
        drive(1, 0, 0, 1, 0, 0, 0, 0);  cycle();
        check("rst_start_ignored_busy", 32'(busy), 0);
        check("rst_start_ignored_count", count, 0);

        // Auto-reload with prescale 1: period 6 cycles; irq_clr on a tc edge loses.
        drive(0, 0, 0, 0, 0, 0, 0, 0);  cycle();
        drive(1, 1, 3, 0, 0, 1, 1, 0);  cycle();
        drive(1, 0, 0, 1, 0, 1, 1, 0);  cycle();
        check("ar_start_count", count, 3);
        ar_exp = '{3, 2, 2, 1, 1, 3, 3, 2, 2, 1, 1, 3};
        drive(1, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 12; i++) begin
            cycle();
            check($sformatf("ar_count%0d", i), count, ar_exp[i]);
            check($sformatf("ar_tc%0d", i), 32'(tc), (i == 5 || i == 11) ? 1 : 0);
        end
        check("ar_irq_sticky", 32'(irq), 1);
        repeat (5) cycle();
        check("ar_pre_tc_count", count, 1);
        drive(1, 0, 0, 0, 0, 1, 1, 1); cycle();
        check("ar_clr_on_tc_tc", 32'(tc), 1);
        check("ar_clr_on_tc_irq", 32'(irq), 1);
        cycle();
        check("ar_clr_alone_irq", 32'(irq), 0);

        // Stop at 5, hold for 10 cycles, resume down to expiry.
        drive(0, 0, 0, 0, 0, 0, 0, 0);  cycle();
        drive(1, 1, 8, 0, 0, 0, 0, 0);  cycle();
        drive(1, 0, 0, 1, 0, 0, 0, 0);  cycle();
        check("sr_start_count", count, 8);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle();
        check("sr_pre_stop_count", count, 5);
        drive(1, 0, 0, 0, 1, 0, 0, 0);  cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check($sformatf("sr_hold_count%0d", i), count, 5);
            check($sformatf("sr_hold_busy%0d", i), 32'(busy), 0);
        end
        drive(1, 0, 0, 1, 0, 0, 0, 0);  cycle();
        check("sr_resume_count", count, 5);
        check("sr_resume_busy", 32'(busy), 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("sr_count%0d", i), count, 4 - i);
            check($sformatf("sr_tc%0d", i), 32'(tc), (i == 4) ? 1 : 0);
        end

        // Load on the same edge as a tick in RUN: load value wins, counting continues.
        drive(0, 0, 0, 0, 0, 0, 0, 0);  cycle();
        drive(1, 1, 20, 0, 0, 0, 0, 0); cycle();
        drive(1, 0, 0, 1, 0, 0, 0, 0);  cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0);  cycle();
        check("ldtick_pre_count", count, 19);
        drive(1, 1, 7, 0, 0, 0, 0, 0);  cycle();
        check("ldtick_count", count, 7);
        check("ldtick_busy", 32'(busy), 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);  cycle();
        check("ldtick_next_count", count, 6);

        // Randomized run against the behavioural model.
        for (int i = 0; i < 4000; i++) begin
            rst_n       = ($urandom_range(199) != 0);
            load        = ($urandom_range(19) == 0);
            load_val    = $urandom_range(12);
            start       = ($urandom_range(9) == 0);
            stop        = ($urandom_range(29) == 0);
            auto_reload = 1'($urandom_range(1));
            prescale    = 8'($urandom_range(3));
            irq_clr     = ($urandom_range(15) == 0);
            cycle();
            check("rnd_count", count, m_count);
            check("rnd_busy", 32'(busy), (m_mode == 1) ? 1 : 0);
            check("rnd_tc", 32'(tc), 32'(m_tc));
            check("rnd_irq", 32'(irq), 32'(m_irq));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Programmable down-counting timer for the MIPS system, built next to the existing up-counter.
- Loads a start value and decrements it once per prescaled tick.
- Emits a one-cycle terminal-count pulse and raises a sticky interrupt flag at zero.
- Runs in one-shot or auto-reload mode.

Parameters:
- WIDTH, 32, width of the count and load value.
- PS_WIDTH, 8, width of the prescale divider.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled only at the rising edge of clk.
- load  input  1  pulse; capture load_val into the reload register and the count.
- load_val  input  WIDTH  start/reload value.
- start  input  1  pulse; begin or resume counting.
- stop  input  1  pulse; pause counting.
- auto_reload  input  1  1 = reload at terminal count and keep running; 0 = one-shot.
- prescale  input  PS_WIDTH  tick every prescale+1 cycles; latched on start.
- irq_clr  input  1  clear the sticky irq.
- count  output  WIDTH  current count value.
- busy  output  1  high while in state RUN.
- tc  output  1  one-cycle registered terminal-count pulse.
- irq  output  1  sticky flag; set on every tc.

Behaviour:
- Reset: rst_n=0 at an edge sets state=T_IDLE, count=0, reload_reg=0, ps_reg=0, ps_cnt=0, tc=0, irq=0, busy=0. Applies mid-operation and has priority over every other input.
- States:
  - T_IDLE: stopped; count is held.
  - T_RUN: counting.
  - T_EXPIRED: one-shot finished; count=0.
- Input priority per edge: rst_n > load > stop > start > tick.
- load: reload_reg<=load_val, count<=load_val, ps_cnt<=0. State is unchanged, except T_EXPIRED->T_IDLE. In T_RUN, counting continues from the new value.
- start in T_IDLE or T_EXPIRED:
  - if count!=0: enter T_RUN from the current count (resume).
  - else if reload_reg!=0: count<=reload_reg, enter T_RUN.
  - else: ignored.
  - On entry, ps_reg<=prescale and ps_cnt<=0.
- start in T_RUN: ignored.
- stop in T_RUN: T_IDLE; count held; ps_cnt<=0. stop in any other state: ignored.
- Tick (T_RUN only):
  - ps_cnt==ps_reg produces a tick and ps_cnt<=0; otherwise ps_cnt increments.
  - ps_reg=0 means a tick every cycle.
- Tick with count>1: count decrements.
- Tick with count==1:
  - tc<=1 and irq<=1 on the same edge.
  - If auto_reload=1: count<=reload_reg and stay in T_RUN, giving a period of reload_reg*(ps_reg+1) cycles.
  - Else: count<=0 and enter T_EXPIRED.
- tc is high exactly one cycle per expiry and 0 otherwise.
- irq: cleared by irq_clr; a set on the same edge as irq_clr wins.
- Latency: with ps_reg=0 and load value N, tc is high in the cycle following the Nth edge after the start edge.
- Width: count arithmetic is unsigned with no wrap, because count never decrements from 0. load_val=0 with start is ignored.
- busy is registered and equals (state==T_RUN).

Decomposition:
- Package timer_pkg holds:
  - typedef enum logic[1:0] timer_state_t {T_IDLE, T_RUN, T_EXPIRED}
  - default width constants.
- Sub-module timer_prescaler (ps_reg, enable, clear -> tick) isolates the divider.
- The FSM, count and irq logic stay in countdown_timer.

Test Plan:
- Reset mid-run: load 10, start, 3 cycles, then rst_n=0 for one edge -> count=0, busy=0, tc=0, irq=0 on that edge; a later start is ignored.
- One-shot: load 5, prescale=0, auto_reload=0, start -> count 5,4,3,2,1,0 on successive edges. tc is high one cycle after the 5th post-start edge, then irq=1, busy=0, state T_EXPIRED.
- Auto-reload: load 3, prescale=1, auto_reload=1, start -> count 3,3,2,2,1,1,3,3,... with a tc pulse every 6 cycles; irq stays 1 until irq_clr.
- Stop/resume: load 8, prescale=0, start, stop when count=5 -> count holds 5 for 10 cycles with busy=0; start -> 4,3,2,1,0 and tc fires.
- Simultaneous events: irq_clr on the tc edge -> irq=1. load 7 on the same edge as a tick in T_RUN -> count=7 (load wins). stop and start together -> T_IDLE.
- Zero cases: after reset, start with reload_reg=0 -> stays in T_IDLE. From T_EXPIRED, start -> reloads reload_reg and runs again.
